// File: rtl/down_mover_pkg.sv
// down_mover_pkg -- game constants shared by the sprite movers and the drawer.
//   move_state_t : mover FSM encoding (IDLE, WAIT, DRAW, DONE)
//   BOTTOM_Y     : lowest legal sprite row
//   X_RIGHT      : column used by the right-hand player (code 2'b11)
//   X_LEFT       : column used by every other player code
//   PLAYER_RIGHT : player code that selects X_RIGHT
//   AT_BOTTOM    : atBottom value once the sprite has landed
package down_mover_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } move_state_t;

  localparam logic [6:0] BOTTOM_Y     = 7'd119;
  localparam logic [7:0] X_RIGHT      = 8'd118;
  localparam logic [7:0] X_LEFT       = 8'd0;
  localparam logic [1:0] PLAYER_RIGHT = 2'b11;
  localparam logic [1:0] AT_BOTTOM    = 2'b11;

endpackage

// File: rtl/down_mover_if.sv
// down_mover_if -- handshake bundle between a game controller and a sprite mover.
//   frame_tick : one-cycle pulse per video frame
//   start      : one-cycle request to begin a move (with player, start_y)
//   player     : player code, selects the sprite column
//   start_y    : starting row
//   plot_ack   : drawer has consumed x/y
//   x, y       : sprite position
//   plot       : x/y valid for drawing, held until plot_ack
//   busy       : move in progress
//   atBottom   : 2'b11 once the sprite has reached the bottom row
// modport master : controller/drawer side; modport slave : mover side.
interface down_mover_if;
  logic       frame_tick;
  logic       start;
  logic [1:0] player;
  logic [6:0] start_y;
  logic       plot_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic       plot;
  logic       busy;
  logic [1:0] atBottom;

  modport master (
    output frame_tick, start, player, start_y, plot_ack,
    input  x, y, plot, busy, atBottom
  );

  modport slave (
    input  frame_tick, start, player, start_y, plot_ack,
    output x, y, plot, busy, atBottom
  );
endinterface

// File: rtl/down_mover_frame_divider.sv
// frame_divider -- counts enabled frame_tick pulses and flags every
// FRAMES_PER_STEP-th one.
//   clock, reset : system clock, asynchronous active-high reset
//   enable       : count this cycle (a qualifying frame_tick)
//   clear        : restart the count from zero
//   tc           : terminal count, high on the FRAMES_PER_STEP-th enabled cycle
module frame_divider #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  logic [3:0] count;

  // tc is combinational so the step happens on the same edge as the pulse.
  assign tc = enable && (count == 4'(FRAMES_PER_STEP - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear || tc)
      count <= '0;
    else if (enable)
      count <= count + 4'd1;
  end

endmodule

// File: rtl/down_mover.sv
// down_mover -- moves a sprite down one STEP every FRAMES_PER_STEP frames,
// handing each new position to the drawer and waiting for its acknowledge,
// until the sprite lands on BOTTOM_Y.
//   clock : system clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : down_mover_if.slave (frame_tick, start, player, start_y,
//           plot_ack in; x, y, plot, busy, atBottom out)
module down_mover #(
  parameter int         FRAMES_PER_STEP = 4,
  parameter logic [6:0] STEP            = 7'd1,
  parameter logic [6:0] BOTTOM_Y        = down_mover_pkg::BOTTOM_Y,
  parameter logic [7:0] X_RIGHT         = down_mover_pkg::X_RIGHT,
  parameter logic [7:0] X_LEFT          = down_mover_pkg::X_LEFT
) (
  input  logic               clock,
  input  logic               reset,
  down_mover_if.slave        bus
);

  import down_mover_pkg::*;

  move_state_t state, state_next;
  logic [7:0]  x_reg;
  logic [6:0]  y_reg;
  logic [1:0]  at_bottom_reg;
  logic        load, advance, finish;
  logic        div_enable, div_clear, div_tc;

  // Starting rows at or below the floor land directly on it.
  function automatic logic [6:0] clamp_start(input logic [6:0] v);
    return (v >= BOTTOM_Y) ? BOTTOM_Y : v;
  endfunction

  // 8-bit sum so a large STEP cannot wrap past 127 before the clamp.
  function automatic logic [6:0] clamp_step(input logic [6:0] v);
    logic [7:0] sum;
    sum = {1'b0, v} + {1'b0, STEP};
    return (sum >= {1'b0, BOTTOM_Y}) ? BOTTOM_Y : sum[6:0];
  endfunction

  frame_divider #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_divider (
    .clock (clock),
    .reset (reset),
    .enable(div_enable),
    .clear (div_clear),
    .tc    (div_tc)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    div_enable = 1'b0;
    div_clear  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          div_clear  = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (bus.plot_ack) begin
          if (y_reg == BOTTOM_Y) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // Only ticks seen in WAIT count; ticks during DRAW are dropped.
        div_enable = bus.frame_tick;
        if (div_tc) begin
          advance    = 1'b1;
          state_next = DRAW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_reg         <= '0;
      y_reg         <= '0;
      at_bottom_reg <= '0;
    end else begin
      if (load) begin
        x_reg         <= (bus.player == PLAYER_RIGHT) ? X_RIGHT : X_LEFT;
        y_reg         <= clamp_start(bus.start_y);
        at_bottom_reg <= 2'b00;
      end
      if (advance)
        y_reg <= clamp_step(y_reg);
      if (finish)
        at_bottom_reg <= AT_BOTTOM;
    end
  end

  assign bus.x        = x_reg;
  assign bus.y        = y_reg;
  assign bus.plot     = (state == DRAW);
  assign bus.busy     = (state == WAIT) || (state == DRAW);
  assign bus.atBottom = at_bottom_reg;

endmodule

// File: tb/tb_down_mover.sv
module tb_down_mover;

  localparam int FPS = 4;
  localparam int BOT = 119;
  localparam int XR  = 118;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sel = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       plot_ack = 1'b0;
  logic [1:0] player = 2'b00;
  logic [6:0] start_y = 7'd0;

  int n_vec = 0;
  int n_err = 0;

  down_mover_if ifa ();
  down_mover_if ifb ();

  assign ifa.frame_tick = frame_tick & ~sel;
  assign ifa.start      = start & ~sel;
  assign ifa.plot_ack   = plot_ack & ~sel;
  assign ifa.player     = player;
  assign ifa.start_y    = start_y;
  assign ifb.frame_tick = frame_tick & sel;
  assign ifb.start      = start & sel;
  assign ifb.plot_ack   = plot_ack & sel;
  assign ifb.player     = player;
  assign ifb.start_y    = start_y;

  down_mover #(.FRAMES_PER_STEP(FPS), .STEP(7'd1)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa)
  );
  down_mover #(.FRAMES_PER_STEP(FPS), .STEP(7'd7)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb)
  );

  logic [7:0] ox;
  logic [6:0] oy;
  logic       oplot, obusy;
  logic [1:0] oatb;
  assign ox    = sel ? ifb.x        : ifa.x;
  assign oy    = sel ? ifb.y        : ifa.y;
  assign oplot = sel ? ifb.plot     : ifa.plot;
  assign obusy = sel ? ifb.busy     : ifa.busy;
  assign oatb  = sel ? ifb.atBottom : ifa.atBottom;

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, ox, 0);
    chk({tag, "_y"}, oy, 0);
    chk({tag, "_plot"}, oplot, 0);
    chk({tag, "_busy"}, obusy, 0);
    chk({tag, "_atb"}, oatb, 0);
  endtask

  // Reference: the expected list of plotted rows is derived from the
  // start row and step with plain arithmetic; timing is checked by
  // counting frame ticks seen since each acknowledge.
  task automatic run_move(input bit s, input logic [1:0] pl, input logic [6:0] sy,
                          input int hold_ticks, input bit poke);
    int yq[$];
    int yv, st, xe, nh, ticks;
    bit prev, t, long_hold;
    st = s ? 7 : 1;
    yv = (int'(sy) >= BOT) ? BOT : int'(sy);
    yq.push_back(yv);
    while (yv != BOT) begin
      yv = (yv + st > BOT) ? BOT : yv + st;
      yq.push_back(yv);
    end
    xe = (pl == 2'b11) ? XR : 0;
    sel = s;
    start = 1'b1; player = pl; start_y = sy;
    step();
    start = 1'b0;
    chk("start_atb", oatb, 0);
    foreach (yq[i]) begin
      chk("draw_plot", oplot, 1);
      chk("draw_busy", obusy, 1);
      chk("draw_x", ox, xe);
      chk("draw_y", oy, yq[i]);
      long_hold = (i == 0) && (hold_ticks > 0);
      nh = long_hold ? 2 * hold_ticks : int'($urandom_range(0, 3));
      for (int c = 0; c < nh; c++) begin
        frame_tick = long_hold ? (c % 2 == 0) : ((c % 2 == 0) && ($urandom_range(0, 1) == 1));
        player = 2'($urandom);
        start = poke;
        start_y = 7'd5;
        step();
        frame_tick = 1'b0; start = 1'b0;
        chk("hold_plot", oplot, 1);
        chk("hold_y", oy, yq[i]);
        chk("hold_x", ox, xe);
      end
      plot_ack = 1'b1;
      step();
      plot_ack = 1'b0;
      chk("ack_plot", oplot, 0);
      if (i == yq.size() - 1) begin
        chk("done_busy", obusy, 0);
        chk("done_atb", oatb, 3);
        chk("done_y", oy, BOT);
        chk("done_x", ox, xe);
        for (int c = 0; c < 8; c++) begin
          frame_tick = (c % 2 == 0);
          plot_ack = 1'($urandom_range(0, 1));
          step();
          frame_tick = 1'b0; plot_ack = 1'b0;
          chk("done_quiet", oplot, 0);
          chk("done_hold_y", oy, BOT);
          chk("done_hold_atb", oatb, 3);
        end
      end else begin
        chk("wait_busy", obusy, 1);
        chk("wait_atb", oatb, 0);
        ticks = 0;
        prev = 1'b0;
        for (int c = 0; c < 300 && ticks < FPS; c++) begin
          t = !prev && (c >= 100 || $urandom_range(0, 2) == 0);
          frame_tick = t;
          plot_ack = 1'($urandom_range(0, 1));
          start = poke && ($urandom_range(0, 3) == 0);
          start_y = 7'd5;
          player = 2'($urandom);
          step();
          frame_tick = 1'b0; plot_ack = 1'b0; start = 1'b0;
          if (t) ticks++;
          prev = t;
          chk("wait_plot", oplot, (ticks == FPS) ? 1 : 0);
          chk("wait_y", oy, (ticks == FPS) ? yq[i + 1] : yq[i]);
        end
      end
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge, both instances.
    #1 reset = 1'b1;
    #2;
    sel = 1'b0; #0; chk_zero("por_a");
    sel = 1'b1; #0; chk_zero("por_b");
    sel = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk_zero("idle_a");

    // Right player from row 100: 20 plots, x=118.
    run_move(1'b0, 2'b11, 7'd100, 0, 1'b0);
    // Start on the floor: a single plot at x=0.
    run_move(1'b0, 2'b01, 7'd119, 0, 1'b0);
    // Step of 7 from 115 clamps to 119.
    run_move(1'b1, 2'b10, 7'd115, 0, 1'b0);
    // Long unacknowledged draw with ticks, plus ignored starts mid-move.
    run_move(1'b0, 2'b11, 7'd110, 10, 1'b1);
    // Same start from DONE restarts from row 5.
    run_move(1'b0, 2'b00, 7'd5, 0, 1'b0);
    // Start row beyond the floor.
    run_move(1'b0, 2'b11, 7'd127, 0, 1'b0);

    // Reset while waiting at row 110.
    sel = 1'b0;
    start = 1'b1; player = 2'b11; start_y = 7'd110;
    step();
    start = 1'b0;
    chk("rst_pre_y", oy, 110);
    plot_ack = 1'b1; step(); plot_ack = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("rst_pre_busy", obusy, 1);
    chk("rst_pre_plot", oplot, 0);
    #2 reset = 1'b1;
    #1 chk_zero("rst_async");
    step();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      frame_tick = (c % 2 == 0);
      plot_ack = 1'($urandom_range(0, 1));
      step();
      frame_tick = 1'b0; plot_ack = 1'b0;
      chk("rst_no_plot", oplot, 0);
      chk("rst_no_busy", obusy, 0);
    end
    run_move(1'b0, 2'b11, 7'd117, 0, 1'b0);

    // Randomized moves on either instance.
    for (int k = 0; k < 4; k++) begin
      run_move(1'($urandom_range(0, 1)), 2'($urandom), 7'($urandom_range(95, 127)), 0, (k % 2 == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
